// File: rtl/multiword_add_seq_if.sv
// multiword_add_seq_if
//   Operand/result bundle for the multi-word add/subtract sequencer.
//   master: issues start/sub/A/B, observes busy/done/Z/Cout/overflow.
//   slave : the sequencer itself.
//   start     request a new operation
//   sub       0: Z = A + B, 1: Z = A - B
//   A, B      W-bit operands (W = N*WORDS)
//   busy      slices in progress
//   done      one-cycle result-valid pulse
//   Z         W-bit result
//   Cout      carry out of the MSB (for sub: 1 = no borrow)
//   overflow  signed overflow of the whole W-bit operation
interface multiword_add_seq_if #(
  parameter int N     = 32,
  parameter int WORDS = 4
);
  localparam int W = N * WORDS;

  logic         start;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Z;
  logic         Cout;
  logic         overflow;

  modport master (
    output start, sub, A, B,
    input  busy, done, Z, Cout, overflow
  );

  modport slave (
    input  start, sub, A, B,
    output busy, done, Z, Cout, overflow
  );
endinterface

// File: rtl/multiword_add_seq.sv
// multiword_add_seq
//   Builds a W-bit (W = N*WORDS) add/subtract out of a single N-bit adder
//   slice, one word per clock, least significant word first, with the carry
//   registered between slices. Latency from accepted start to done is
//   WORDS+1 cycles.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    slave side of multiword_add_seq_if (start/sub/A/B in,
//          busy/done/Z/Cout/overflow out)
//
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | processing slice idx_q (0..WORDS-1)
//   DONE   | result valid for one cycle; start here chains straight into RUN
module multiword_add_seq #(
  parameter int N     = 32,
  parameter int WORDS = 4
) (
  input logic               clk,
  input logic               rst_n,
  multiword_add_seq_if.slave bus
);
  localparam int W     = N * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       z_q, z_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               busy, done, accept, last_slice;
  logic [N-1:0]       a_word, b_word;
  logic [N:0]         slice_sum;
  logic               carry_into_msb;

  assign last_slice = (idx_q == IDX_W'(WORDS - 1));

  // Single N-bit slice; b_q already holds ~B for subtraction.
  assign a_word    = a_q[int'(idx_q)*N +: N];
  assign b_word    = b_q[int'(idx_q)*N +: N];
  assign slice_sum = {1'b0, a_word} + {1'b0, b_word} + {{N{1'b0}}, carry_q};
  // Carry into the top bit recovered from that bit's sum and operands.
  assign carry_into_msb = slice_sum[N-1] ^ a_word[N-1] ^ b_word[N-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_slice) state_d = S_DONE;
      S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == S_RUN);
    done   = (state_q == S_DONE);
    accept = bus.start && (state_q != S_RUN);
  end

  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_d     = bus.A;
      b_d     = bus.sub ? ~bus.B : bus.B;
      carry_d = bus.sub;
      idx_d   = '0;
      z_d     = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (busy) begin
      z_d[int'(idx_q)*N +: N] = slice_sum[N-1:0];
      carry_d = slice_sum[N];
      if (last_slice) begin
        idx_d  = '0;
        cout_d = slice_sum[N];
        ovf_d  = slice_sum[N] ^ carry_into_msb;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.Z        = z_q;
  assign bus.Cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq
//   Scoreboarded bench for multiword_add_seq at N=32, WORDS=4 (W=128).
//   Expected results come from a plain 129-bit reference sum pushed when
//   each operation is issued; a negedge monitor pops and compares on done.
module tb_multiword_add_seq;
  localparam int N     = 32;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  typedef struct packed {
    logic [W-1:0] z;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   done_cnt;
  exp_t sb_q[$];
  exp_t last_exp;

  multiword_add_seq_if #(.N(N), .WORDS(WORDS)) bus ();

  multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t         r;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb     = s ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + (W+1)'(s);
    r.z    = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == bb[W-1]) && (r.z[W-1] != a[W-1]);
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      done_cnt++;
      chk("busy_with_done", W'(bus.busy), W'(0));
      if (sb_q.size() == 0) begin
        chk("unexpected_done", W'(1), W'(0));
      end else begin
        e = sb_q.pop_front();
        chk("z", bus.Z, e.z);
        chk("cout", W'(bus.Cout), W'(e.cout));
        chk("overflow", W'(bus.overflow), W'(e.ovf));
        last_exp = e;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.A     = a;
    bus.B     = b;
    bus.sub   = s;
    bus.start = 1'b1;
    sb_q.push_back(model(a, b, s));
  endtask

  // Advances negedge by negedge until done; cyc counts negedges already seen.
  task automatic wait_done(inout int cyc);
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.done !== 1'b1) chk("timeout_done", W'(0), W'(1));
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int cyc;
    @(negedge clk);
    issue(a, b, s);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    chk("busy_after_start", W'(bus.busy), W'(1));
    wait_done(cyc);
    chk("latency", W'(cyc), W'(WORDS + 1));
    @(negedge clk);
    chk("done_one_cycle", W'(bus.done), W'(0));
    chk("z_hold", bus.Z, last_exp.z);
  endtask

  initial begin
    int cyc;
    int d0;
    logic [W-1:0] ra, rb;
    n_checks  = 0;
    n_errors  = 0;
    done_cnt  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_done", W'(bus.done), W'(0));
    chk("rst_z", bus.Z, W'(0));
    chk("rst_cout", W'(bus.Cout), W'(0));
    chk("rst_ovf", W'(bus.overflow), W'(0));
    rst_n = 1'b1;

    run_op(W'(1), {W{1'b1}}, 1'b0);
    run_op(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, W'(1), 1'b0);
    run_op(W'(5), W'(7), 1'b1);
    run_op({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0);
    run_op({1'b1, {(W-1){1'b0}}}, W'(1), 1'b1);
    run_op(W'(7), W'(5), 1'b1);

    for (int i = 0; i < 6; i++) begin
      ra = {$urandom(), $urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    // start pulses during RUN must be ignored
    d0 = done_cnt;
    @(negedge clk);
    issue(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    @(negedge clk);
    cyc++;
    bus.A = {W{1'b1}};
    bus.B = {W{1'b1}};
    bus.start = 1'b1;
    @(negedge clk);
    cyc++;
    bus.start = 1'b0;
    wait_done(cyc);
    chk("ignore_latency", W'(cyc), W'(WORDS + 1));
    repeat (6) @(negedge clk);
    chk("ignore_single_done", W'(done_cnt - d0), W'(1));

    // start in the done cycle chains directly into the next operation
    @(negedge clk);
    issue(W'(100), W'(58), 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    wait_done(cyc);
    issue({W{1'b1}}, {W{1'b1}}, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy", W'(bus.busy), W'(1));
    chk("b2b_no_done", W'(bus.done), W'(0));
    cyc = 1;
    wait_done(cyc);
    chk("b2b_latency", W'(cyc), W'(WORDS + 1));
    repeat (2) @(negedge clk);

    // reset in RUN cycle 2 discards the operation
    d0 = done_cnt;
    @(negedge clk);
    bus.A = W'(5);
    bus.B = W'(7);
    bus.sub = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("partial_z", bus.Z, W'(12));
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", W'(bus.busy), W'(0));
    chk("midrst_done", W'(bus.done), W'(0));
    chk("midrst_z", bus.Z, W'(0));
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_no_done", W'(done_cnt - d0), W'(0));

    run_op(W'(3), W'(4), 1'b0);

    chk("sb_empty", W'(sb_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end
endmodule
